// File: rtl/axis_frame_stats_pkg.sv
// Shared definitions for the AXI-Stream frame statistics monitor:
// status-record layout and counter saturation constants.
package axis_frame_stats_pkg;

  // Record layout is {len, runt, oversize}; the flags sit below the length field.
  localparam int unsigned REC_FLAG_WIDTH   = 2;
  localparam int unsigned REC_RUNT_IDX     = 1;
  localparam int unsigned REC_OVERSIZE_IDX = 0;

  // Saturating counters stop at a value made entirely of this bit.
  localparam logic SAT_FILL_BIT = 1'b1;
  localparam logic SAT_INCR_BIT = 1'b1;

  function automatic int unsigned rec_width(input int unsigned len_width);
    return len_width + REC_FLAG_WIDTH;
  endfunction

endpackage

// File: rtl/axis_frame_stats_fifo.sv
// Synchronous FIFO for frame status records. The head entry is held in an
// output register, so the data and valid outputs come straight from flops.
module axis_frame_stats_fifo
  import axis_frame_stats_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W:0]   w_remain;
  logic [PTR_W:0]   w_count_nxt;
  logic [WIDTH-1:0] w_data_nxt;

  assign w_pop        = r_valid & i_ready;
  assign w_full       = (r_count == (PTR_W+1)'(DEPTH));
  assign w_push_ok    = i_push & (~w_full | w_pop);
  assign o_drop       = i_push & w_full & ~w_pop;
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
  assign w_remain     = r_count - (PTR_W+1)'(w_pop);
  assign w_count_nxt  = w_remain + (PTR_W+1)'(w_push_ok);

  // Next head: a push into an otherwise-empty FIFO bypasses the memory.
  always_comb begin
    w_data_nxt = '0;
    if (w_count_nxt == '0) begin
      w_data_nxt = '0;
    end else if (w_remain == '0) begin
      w_data_nxt = i_data;
    end else begin
      w_data_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array, written at the tail on every accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_ok);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= (w_count_nxt != '0);
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/axis_frame_stats.sv
// AXI-Stream frame monitor: measures frame lengths from tkeep, flags runt and
// oversize frames, buffers per-frame status records and keeps running statistics.
module axis_frame_stats
  import axis_frame_stats_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LEN_WIDTH   = 16,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic                  monitor_axis_tvalid,
  input  logic                  monitor_axis_tready,
  input  logic                  monitor_axis_tlast,
  output logic [LEN_WIDTH-1:0]  status_len,
  output logic                  status_runt,
  output logic                  status_oversize,
  output logic                  status_valid,
  input  logic                  status_ready,
  input  logic                  stat_clear,
  output logic [CNT_WIDTH-1:0]  stat_frame_count,
  output logic [CNT_WIDTH-1:0]  stat_drop_count,
  output logic [LEN_WIDTH-1:0]  stat_min_len,
  output logic [LEN_WIDTH-1:0]  stat_max_len
);

  localparam int KEEP_BITS = (KEEP_WIDTH < DATA_WIDTH) ? KEEP_WIDTH : DATA_WIDTH;
  localparam int REC_WIDTH = int'(rec_width(LEN_WIDTH));
  localparam logic [LEN_WIDTH-1:0] MIN_LEN_L = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_SAT   = {LEN_WIDTH{SAT_FILL_BIT}};
  localparam logic [CNT_WIDTH-1:0] CNT_SAT   = {CNT_WIDTH{SAT_FILL_BIT}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(SAT_INCR_BIT);

  logic [LEN_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic [LEN_WIDTH-1:0] r_min_len;
  logic [LEN_WIDTH-1:0] r_max_len;

  logic                 w_beat;
  logic                 w_frame_end;
  logic [LEN_WIDTH-1:0] w_beat_bytes;
  logic [LEN_WIDTH:0]   w_sum;
  logic [LEN_WIDTH-1:0] w_len;
  logic                 w_runt;
  logic                 w_over;
  logic                 w_drop;
  logic [REC_WIDTH-1:0] w_rec;
  logic [CNT_WIDTH-1:0] w_fc_base, w_fc_nxt;
  logic [CNT_WIDTH-1:0] w_dc_base, w_dc_nxt;
  logic [LEN_WIDTH-1:0] w_min_base, w_min_nxt;
  logic [LEN_WIDTH-1:0] w_max_base, w_max_nxt;

  assign w_beat      = monitor_axis_tvalid & monitor_axis_tready;
  assign w_frame_end = w_beat & monitor_axis_tlast;

  // Bytes carried by one beat: popcount of tkeep, or a single byte without keep.
  always_comb begin
    w_beat_bytes = '0;
    if (KEEP_ENABLE != 0) begin
      for (int i = 0; i < KEEP_BITS; i++) begin
        w_beat_bytes = w_beat_bytes + LEN_WIDTH'(monitor_axis_tkeep[i]);
      end
    end else begin
      w_beat_bytes = LEN_WIDTH'(1'b1);
    end
  end

  assign w_sum  = {1'b0, r_acc} + {1'b0, w_beat_bytes};
  assign w_len  = w_sum[LEN_WIDTH] ? LEN_SAT : w_sum[LEN_WIDTH-1:0];
  assign w_runt = (w_len < MIN_LEN_L);
  assign w_over = (w_len > MAX_LEN_L);

  // Length accumulator; restarts after every accepted tlast beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_frame_end) begin
      r_acc <= '0;
    end else if (w_beat) begin
      r_acc <= w_len;
    end else begin
      r_acc <= r_acc;
    end
  end

  axis_frame_stats_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_frame_end),
    .i_data  ({w_len, w_runt, w_over}),
    .i_ready (status_ready),
    .o_data  (w_rec),
    .o_valid (status_valid),
    .o_drop  (w_drop)
  );

  assign status_len      = w_rec[REC_WIDTH-1 -: LEN_WIDTH];
  assign status_runt     = w_rec[REC_RUNT_IDX];
  assign status_oversize = w_rec[REC_OVERSIZE_IDX];

  // Statistics update: a clear sets the base, a completing frame lands on top of it.
  always_comb begin
    w_fc_base  = stat_clear ? '0      : r_frame_cnt;
    w_dc_base  = stat_clear ? '0      : r_drop_cnt;
    w_min_base = stat_clear ? LEN_SAT : r_min_len;
    w_max_base = stat_clear ? '0      : r_max_len;
    w_fc_nxt   = w_fc_base;
    w_dc_nxt   = w_dc_base;
    w_min_nxt  = w_min_base;
    w_max_nxt  = w_max_base;
    if (w_frame_end) begin
      w_fc_nxt  = (w_fc_base == CNT_SAT) ? w_fc_base : w_fc_base + CNT_ONE;
      w_min_nxt = (w_len < w_min_base) ? w_len : w_min_base;
      w_max_nxt = (w_len > w_max_base) ? w_len : w_max_base;
    end else begin
      w_fc_nxt  = w_fc_base;
    end
    if (w_drop) begin
      w_dc_nxt = (w_dc_base == CNT_SAT) ? w_dc_base : w_dc_base + CNT_ONE;
    end else begin
      w_dc_nxt = w_dc_base;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_min_len   <= LEN_SAT;
      r_max_len   <= '0;
    end else begin
      r_frame_cnt <= w_fc_nxt;
      r_drop_cnt  <= w_dc_nxt;
      r_min_len   <= w_min_nxt;
      r_max_len   <= w_max_nxt;
    end
  end

  assign stat_frame_count = r_frame_cnt;
  assign stat_drop_count  = r_drop_cnt;
  assign stat_min_len     = r_min_len;
  assign stat_max_len     = r_max_len;

endmodule

// File: tb/tb_axis_frame_stats.sv
// Directed self-checking bench for axis_frame_stats with hand-computed expectations.
module tb_axis_frame_stats;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [15:0] status_len;
  logic        status_runt;
  logic        status_oversize;
  logic        status_valid;
  logic        status_ready;
  logic        stat_clear;
  logic [31:0] stat_frame_count;
  logic [31:0] stat_drop_count;
  logic [15:0] stat_min_len;
  logic [15:0] stat_max_len;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axis_frame_stats #(
    .DATA_WIDTH (64),
    .KEEP_ENABLE(1),
    .KEEP_WIDTH (8),
    .LEN_WIDTH  (16),
    .MIN_LEN    (64),
    .MAX_LEN    (1518),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .monitor_axis_tkeep  (tkeep),
    .monitor_axis_tvalid (tvalid),
    .monitor_axis_tready (tready),
    .monitor_axis_tlast  (tlast),
    .status_len          (status_len),
    .status_runt         (status_runt),
    .status_oversize     (status_oversize),
    .status_valid        (status_valid),
    .status_ready        (status_ready),
    .stat_clear          (stat_clear),
    .stat_frame_count    (stat_frame_count),
    .stat_drop_count     (stat_drop_count),
    .stat_min_len        (stat_min_len),
    .stat_max_len        (stat_max_len)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] keep, input logic last);
    @(negedge clk);
    tvalid = 1'b1;
    tkeep  = keep;
    tlast  = last;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = 8'h00;
  endtask

  task automatic send_frame(input int nfull, input logic [7:0] last_keep);
    for (int i = 0; i < nfull; i++) begin
      send_beat(8'hFF, 1'b0);
    end
    send_beat(last_keep, 1'b1);
  endtask

  task automatic pop_expect(input string tag, input int len, input logic runt, input logic over);
    check_val({tag, "_valid"}, 64'(status_valid), 64'd1);
    check_val({tag, "_len"}, 64'(status_len), 64'(len));
    check_val({tag, "_runt"}, 64'(status_runt), 64'(runt));
    check_val({tag, "_over"}, 64'(status_oversize), 64'(over));
    @(negedge clk);
    status_ready = 1'b1;
    @(posedge clk);
    #1;
    status_ready = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int fc, input int dc, input int mn, input int mx);
    check_val({tag, "_frames"}, 64'(stat_frame_count), 64'(fc));
    check_val({tag, "_drops"}, 64'(stat_drop_count), 64'(dc));
    check_val({tag, "_min"}, 64'(stat_min_len), 64'(mn));
    check_val({tag, "_max"}, 64'(stat_max_len), 64'(mx));
  endtask

  initial begin
    logic [7:0] keep_tbl [6];
    keep_tbl[0] = 8'h01; keep_tbl[1] = 8'h03; keep_tbl[2] = 8'h07;
    keep_tbl[3] = 8'h0F; keep_tbl[4] = 8'h1F; keep_tbl[5] = 8'h3F;

    rst_n = 1'b0; tkeep = 8'h00; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
    status_ready = 1'b0; stat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(status_valid), 64'd0);
    check_val("rst_len", 64'(status_len), 64'd0);
    check_val("rst_runt", 64'(status_runt), 64'd0);
    check_val("rst_over", 64'(status_oversize), 64'd0);
    check_stats("rst", 0, 0, 16'hFFFF, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8 counted beats = 60 bytes; a stalled beat (tready low, even with tlast) is ignored
    for (int i = 0; i < 7; i++) begin
      send_beat(8'hFF, 1'b0);
      if (i == 2) begin
        @(negedge clk);
        tvalid = 1'b1; tready = 1'b0; tkeep = 8'hFF; tlast = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
      end
    end
    check_val("pre_tlast_valid", 64'(status_valid), 64'd0);
    send_beat(8'h0F, 1'b1);
    pop_expect("f60", 60, 1'b1, 1'b0);
    check_val("f60_drained", 64'(status_valid), 64'd0);
    check_stats("f60", 1, 0, 60, 60);

    send_frame(189, 8'hFF);
    pop_expect("f1520", 1520, 1'b0, 1'b1);
    check_stats("f1520", 2, 0, 60, 1520);

    send_frame(189, 8'h3F);
    pop_expect("f1518", 1518, 1'b0, 1'b0);
    send_frame(7, 8'hFF);
    pop_expect("f64", 64, 1'b0, 1'b0);

    send_beat(8'hA5, 1'b1);
    pop_expect("fA5", 4, 1'b1, 1'b0);
    check_stats("fA5", 5, 0, 4, 1520);

    send_beat(8'h00, 1'b1);
    pop_expect("f0", 0, 1'b1, 1'b0);
    check_stats("f0", 6, 0, 0, 1520);

    // clear on the tlast edge of a 100-byte frame
    for (int i = 0; i < 12; i++) begin
      send_beat(8'hFF, 1'b0);
    end
    @(negedge clk);
    stat_clear = 1'b1; tvalid = 1'b1; tkeep = 8'h0F; tlast = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    check_stats("clr_tlast", 1, 0, 100, 100);
    pop_expect("f100", 100, 1'b0, 1'b0);

    // clear mid-frame leaves the accumulator alone
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    @(negedge clk);
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    check_stats("clr_mid", 0, 0, 16'hFFFF, 0);
    send_beat(8'h01, 1'b1);
    pop_expect("f17", 17, 1'b1, 1'b0);
    @(negedge clk);
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;

    // six frames with no consumer: four buffered, two dropped
    for (int i = 0; i < 6; i++) begin
      send_beat(keep_tbl[i], 1'b1);
    end
    check_stats("ovf", 6, 2, 1, 6);
    for (int i = 0; i < 4; i++) begin
      pop_expect($sformatf("drain%0d", i + 1), i + 1, 1'b1, 1'b0);
    end
    check_val("ovf_empty", 64'(status_valid), 64'd0);

    // full FIFO with a pop on the same edge accepts the push
    for (int i = 0; i < 4; i++) begin
      send_beat(keep_tbl[i], 1'b1);
    end
    @(negedge clk);
    status_ready = 1'b1; tvalid = 1'b1; tkeep = 8'h1F; tlast = 1'b1;
    @(posedge clk);
    #1;
    status_ready = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    check_stats("full_pop", 11, 2, 1, 6);
    for (int i = 0; i < 4; i++) begin
      pop_expect($sformatf("fp%0d", i + 2), i + 2, 1'b1, 1'b0);
    end
    check_val("fp_empty", 64'(status_valid), 64'd0);

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 3; i++) begin
      send_beat(8'hFF, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_frames", 64'(stat_frame_count), 64'd0);
    check_val("mid_rst_min", 64'(stat_min_len), 64'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1, 8'hFF);
    pop_expect("f16", 16, 1'b1, 1'b0);
    check_stats("f16", 1, 0, 16, 16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_frame_stats.md
AXIS_FRAME_STATS -- requirements
Module: axis_frame_stats

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: monitored data width in bits.
REQ-002 SHALL have parameter KEEP_ENABLE, default (DATA_WIDTH>8): honour tkeep; when 0, each beat counts 1 byte.
REQ-003 SHALL have parameter KEEP_WIDTH, default (DATA_WIDTH/8): tkeep width.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: frame length width.
REQ-005 SHALL have parameter MIN_LEN, default 64: runt threshold in bytes.
REQ-006 SHALL have parameter MAX_LEN, default 1518: oversize threshold in bytes.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4: status records buffered, power of two, at least 2.
REQ-008 SHALL have parameter CNT_WIDTH, default 32: statistics counter width.
REQ-009 SHALL have ports, clock and reset first: clk in 1, single clock; rst_n in 1, asynchronous active-low reset; monitor_axis_tkeep in KEEP_WIDTH; monitor_axis_tvalid in 1; monitor_axis_tready in 1; monitor_axis_tlast in 1.
REQ-010 SHALL have status ports: status_len out LEN_WIDTH; status_runt out 1; status_oversize out 1; status_valid out 1; status_ready in 1.
REQ-011 SHALL have statistics ports: stat_clear in 1; stat_frame_count out CNT_WIDTH; stat_drop_count out CNT_WIDTH; stat_min_len out LEN_WIDTH; stat_max_len out LEN_WIDTH.

Function
REQ-012 SHALL count a beat only when tvalid and tready are both high; the beat adds popcount(tkeep), so sparse and non-contiguous keep are allowed.
REQ-013 SHALL saturate the length accumulator at all-ones and never wrap.
REQ-014 SHALL, on a tlast beat, form a record: len = accumulated length including that beat; runt = len < MIN_LEN; oversize = len > MAX_LEN; the accumulator restarts at 0 for the next beat.
REQ-015 SHALL push the record into the status FIFO on the clock edge that accepts the tlast beat; status_valid SHALL rise the following cycle when the FIFO was empty.
REQ-016 SHALL pop the FIFO when status_valid and status_ready are both high; status outputs SHALL stay stable while valid and not ready.
REQ-017 SHALL drop the record when the FIFO is full and no pop occurs on the same edge, and SHALL increment stat_drop_count, saturating.
REQ-018 SHALL accept a push when the FIFO is full and a pop occurs on the same edge.
REQ-019 SHALL, per completed frame, including dropped frames: increment stat_frame_count, saturating; set stat_min_len = min(stat_min_len, len); set stat_max_len = max(stat_max_len, len).
REQ-020 SHALL make stat_clear synchronous: counters go to 0, stat_min_len to all-ones, stat_max_len to 0; a frame ending on the same edge is applied on top of the cleared values.
REQ-021 SHALL NOT let stat_clear affect the accumulator or the FIFO.
REQ-022 SHALL treat a one-beat frame with tkeep all zeros as len 0 with runt set.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously set the accumulator to 0, empty the FIFO, drive status_valid 0, status_len 0 and both flags 0, set both counters to 0, stat_min_len to all-ones and stat_max_len to 0.
REQ-024 SHALL, on reset mid-frame, discard the partial frame; the first tlast after release reports only beats accepted after release.

Structure
REQ-025 SHALL place the shared status-record field widths and the count-saturation constants in the shared axis package.
REQ-026 SHALL implement the buffer as sub-module axis_frame_stats_fifo: synchronous FIFO of {len, runt, oversize} with registered outputs.

Verification (KEEP_WIDTH=8, MIN_LEN=64, MAX_LEN=1518, FIFO_DEPTH=4)
REQ-027 SHALL cover: 8 full beats with the last having tkeep=0x0F -> status_len=60, runt=1, oversize=0, status_valid one cycle after the tlast beat.
REQ-028 SHALL cover: 190 full beats -> len=1520, oversize=1, stat_max_len=1520.
REQ-029 SHALL cover: tkeep=0xA5 single-beat frame -> len=4; then stat_min_len=4.
REQ-030 SHALL cover: status_ready held low for 6 frames -> 4 records buffered, stat_drop_count=2, stat_frame_count=6, and records later drain in order.
REQ-031 SHALL cover: stat_clear on the tlast edge of a 100-byte frame -> stat_frame_count=1, stat_min_len=stat_max_len=100.
REQ-032 SHALL cover: rst_n pulsed low after 3 beats, then 2 full beats with tlast -> len=16.
